retired_freelist: RTL and testbench

Commit-side (architectural) free list for the renamer. Driven at ROB commit alongside the RRAT. Tracks which physical registers are free as of the last retired instruction. Forwards each freed physical register to the speculative free list as a same-cycle enqueue, and continuously exposes its full 32-entry image plus head/tail pointers, which the speculative free list loads wholesale on a flush.

---
 rtl/retired_freelist.sv | 75 +++++++
 tb/tb_retired_freelist.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/retired_freelist.sv
// Commit-side free list: records physical registers freed at retirement and
// exposes its full image so the speculative free list can reload on a flush.
module retired_freelist #(
    parameter int QUEUE_WIDTH = 6,
    parameter int QUEUE_DEPTH = 32,
    parameter int BIT_DEPTH   = 6
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   commit_valid,
    input  logic [4:0]             commit_rd,
    input  logic [QUEUE_WIDTH-1:0] commit_pd,
    input  logic [QUEUE_WIDTH-1:0] commit_old_pd,
    output logic                   freelist_enqueue,
    output logic [QUEUE_WIDTH-1:0] freelist_enqueue_wdata,
    output logic [QUEUE_WIDTH-1:0] retired_freelist_entries [QUEUE_DEPTH],
    output logic [BIT_DEPTH-1:0]   retired_head_ptr,
    output logic [BIT_DEPTH-1:0]   retired_tail_ptr,
    output logic                   alloc_mismatch
);

    localparam int IDX_W = BIT_DEPTH - 1;

    logic [QUEUE_WIDTH-1:0] entries_r [QUEUE_DEPTH];
    logic [BIT_DEPTH-1:0]   head_r;
    logic [BIT_DEPTH-1:0]   tail_r;
    logic                   mismatch_r;
    logic                   retire_s;
    logic                   pd_differs_s;

    // Decode a retiring write; rd=0 never owned a physical register
    always_comb begin
        retire_s               = 1'b0;
        pd_differs_s           = 1'b0;
        freelist_enqueue       = 1'b0;
        freelist_enqueue_wdata = {QUEUE_WIDTH{1'b0}};
        if (commit_valid && (commit_rd != 5'd0) && !rst) begin
            retire_s               = 1'b1;
            freelist_enqueue       = 1'b1;
            freelist_enqueue_wdata = commit_old_pd;
            pd_differs_s           = (commit_pd != entries_r[head_r[IDX_W-1:0]]);
        end else begin
            retire_s = 1'b0;
        end
    end

    // Retired free-list state; the reset image matches the speculative list
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                entries_r[i] <= QUEUE_WIDTH'(QUEUE_DEPTH + i);
            end
            head_r     <= {BIT_DEPTH{1'b0}};
            tail_r     <= BIT_DEPTH'(QUEUE_DEPTH);
            mismatch_r <= 1'b0;
        end else if (retire_s) begin
            entries_r[tail_r[IDX_W-1:0]] <= commit_old_pd;
            tail_r <= tail_r + BIT_DEPTH'(1);
            head_r <= head_r + BIT_DEPTH'(1);
            // Sticky: rename and commit must drain the list in the same order
            if (pd_differs_s) begin
                mismatch_r <= 1'b1;
            end
        end
    end

    // Snapshot outputs come straight from registers
    always_comb begin
        retired_freelist_entries = entries_r;
        retired_head_ptr         = head_r;
        retired_tail_ptr         = tail_r;
        alloc_mismatch           = mismatch_r;
    end

endmodule

// File: tb/tb_retired_freelist.sv
// Directed self-checking bench for retired_freelist with a small reference model.
module tb_retired_freelist;

    logic       clk;
    logic       rst;
    logic       commit_valid;
    logic [4:0] commit_rd;
    logic [5:0] commit_pd;
    logic [5:0] commit_old_pd;
    logic       freelist_enqueue;
    logic [5:0] freelist_enqueue_wdata;
    logic [5:0] retired_freelist_entries [32];
    logic [5:0] retired_head_ptr;
    logic [5:0] retired_tail_ptr;
    logic       alloc_mismatch;

    int err_cnt;
    int chk_cnt;

    logic [5:0] m_entries [32];
    logic [5:0] m_head;
    logic [5:0] m_tail;
    logic       m_mm;

    retired_freelist dut (
        .clk                      (clk),
        .rst                      (rst),
        .commit_valid             (commit_valid),
        .commit_rd                (commit_rd),
        .commit_pd                (commit_pd),
        .commit_old_pd            (commit_old_pd),
        .freelist_enqueue         (freelist_enqueue),
        .freelist_enqueue_wdata   (freelist_enqueue_wdata),
        .retired_freelist_entries (retired_freelist_entries),
        .retired_head_ptr         (retired_head_ptr),
        .retired_tail_ptr         (retired_tail_ptr),
        .alloc_mismatch           (alloc_mismatch)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Occupancy invariant: tail - head is always 32 (mod 64)
    always @(negedge clk) begin
        logic [5:0] occ;
        occ = retired_tail_ptr - retired_head_ptr;
        check("invariant", 32'(occ), 32'd32);
    end

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_entries[i] = 6'(32 + i);
        m_head = 6'd0;
        m_tail = 6'd32;
        m_mm   = 1'b0;
    endtask

    task automatic check_state(input string tag);
        check({tag, ".head"}, 32'(retired_head_ptr), 32'(m_head));
        check({tag, ".tail"}, 32'(retired_tail_ptr), 32'(m_tail));
        check({tag, ".mm"}, 32'(alloc_mismatch), 32'(m_mm));
        for (int i = 0; i < 32; i++) begin
            if (retired_freelist_entries[i] !== m_entries[i]) begin
                check({tag, ".entry"}, 32'(retired_freelist_entries[i]), 32'(m_entries[i]));
            end
        end
    endtask

    // Called at posedge+1; returns at the following posedge+1
    task automatic do_commit(input logic [4:0] rd, input logic [5:0] pd, input logic [5:0] old_pd);
        commit_valid  = 1'b1;
        commit_rd     = rd;
        commit_pd     = pd;
        commit_old_pd = old_pd;
        #1;
        check("enq", 32'(freelist_enqueue), (rd != 5'd0) ? 32'd1 : 32'd0);
        check("wdata", 32'(freelist_enqueue_wdata), (rd != 5'd0) ? 32'(old_pd) : 32'd0);
        if (rd != 5'd0) begin
            if (pd != m_entries[m_head[4:0]]) m_mm = 1'b1;
            m_entries[m_tail[4:0]] = old_pd;
            m_tail = m_tail + 6'd1;
            m_head = m_head + 6'd1;
        end
        @(posedge clk);
        #1;
        commit_valid = 1'b0;
    endtask

    // Assert rst between edges, check the image before any edge, release later
    task automatic apply_reset(input string tag);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check({tag, ".enq_in_rst"}, 32'(freelist_enqueue), 32'd0);
        check_state(tag);
        @(posedge clk);
        #1;
        rst = 1'b0;
        commit_valid = 1'b0;
    endtask

    initial begin
        err_cnt = 0;
        chk_cnt = 0;
        rst = 1'b1;
        commit_valid = 1'b0;
        commit_rd = 5'd0;
        commit_pd = 6'd0;
        commit_old_pd = 6'd0;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset image and async reset between edges
        apply_reset("reset");
        check("reset.e0", 32'(retired_freelist_entries[0]), 32'd32);
        check("reset.e31", 32'(retired_freelist_entries[31]), 32'd63);

        // Single commit
        do_commit(5'd5, 6'd32, 6'd5);
        check("single.e0", 32'(retired_freelist_entries[0]), 32'd5);
        check("single.head", 32'(retired_head_ptr), 32'd1);
        check("single.tail", 32'(retired_tail_ptr), 32'd33);
        check("single.mm", 32'(alloc_mismatch), 32'd0);

        // rd=0 commit changes nothing
        do_commit(5'd0, 6'd40, 6'd0);
        check_state("rd0");
        check("rd0.head", 32'(retired_head_ptr), 32'd1);

        // Wrap-around: 64 commits with matching pd
        apply_reset("wrap_rst");
        for (int i = 0; i < 64; i++) begin
            do_commit(5'(1 + (i % 31)), m_entries[m_head[4:0]], 6'(i));
            if (i == 31) begin
                check("wrap32.head", 32'(retired_head_ptr), 32'd32);
                check("wrap32.tail", 32'(retired_tail_ptr), 32'd0);
            end
        end
        check("wrap64.head", 32'(retired_head_ptr), 32'd0);
        check("wrap64.tail", 32'(retired_tail_ptr), 32'd32);
        check("wrap64.mm", 32'(alloc_mismatch), 32'd0);
        check("wrap64.e0", 32'(retired_freelist_entries[0]), 32'd32);
        check("wrap64.e31", 32'(retired_freelist_entries[31]), 32'd63);
        check_state("wrap64");

        // Mismatch is sticky and pointers still advance
        apply_reset("mm_rst");
        do_commit(5'd3, 6'd33, 6'd3);
        check("mm.flag", 32'(alloc_mismatch), 32'd1);
        check("mm.head", 32'(retired_head_ptr), 32'd1);
        do_commit(5'd4, 6'd33, 6'd4);
        do_commit(5'd6, 6'd34, 6'd6);
        check("mm.sticky", 32'(alloc_mismatch), 32'd1);
        check_state("mm");

        // Reset mid-stream with a concurrent commit
        apply_reset("mid_pre");
        for (int i = 0; i < 10; i++) begin
            do_commit(5'd7, m_entries[m_head[4:0]], 6'(i + 1));
        end
        check("mid.head", 32'(retired_head_ptr), 32'd10);
        commit_valid  = 1'b1;
        commit_rd     = 5'd7;
        commit_pd     = 6'd42;
        commit_old_pd = 6'd9;
        apply_reset("mid");
        @(posedge clk);
        #1;
        check_state("mid_after");

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got 0 expected 1");
        $fatal(1);
    end

endmodule
